// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pkg : opcode/state enums and flag bit positions shared by seq_alu
// Revision: 1.0
// ----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_LSL  = 4'b0101,
    OP_LSR  = 4'b0110,
    OP_MOV  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_ASR  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_SLT  = 4'b1011
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

endpackage
`default_nettype wire

// File: rtl/seq_mul.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_mul : iterative shift-add multiplier, one multiplier bit per cycle
// Revision: 1.0
// ----------------------------------------------------------------------------
module seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                 r_active;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_partial;
  logic [2*WIDTH-1:0]   w_acc_next;

  assign w_partial  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_partial;

  // The final partial product is folded in combinationally so the caller can
  // capture the full product on the same edge that done is seen.
  assign done    = r_active && (r_cnt == '0);
  assign product = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= CNT_W'(WIDTH - 1);
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_alu : registered ALU with valid/ready handshake and iterative multiply
// Revision: 1.0
// ----------------------------------------------------------------------------
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carryout,
  output logic             overflow,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_flags;

  alu_op_t              w_op;
  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_mul_start;
  logic                 w_mul_done;
  logic                 w_single_load;
  logic                 w_mul_load;
  logic [2*WIDTH-1:0]   w_product;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH:0]       w_lsl;
  logic [WIDTH:0]       w_lsr;
  logic signed [WIDTH:0] w_asr;
  logic [WIDTH-1:0]     w_sc_res;
  logic                 w_sc_c;
  logic                 w_sc_v;
  logic [3:0]           w_sc_flags;
  logic [WIDTH-1:0]     w_mul_res;
  logic [3:0]           w_mul_flags;

  assign w_op          = alu_op_t'(alu_op);
  assign w_is_mul      = (w_op == OP_MUL);
  assign in_ready      = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_mul_start   = w_accept && w_is_mul;
  assign w_single_load = w_accept && !w_is_mul;
  assign w_mul_load    = (r_state == MUL) && w_mul_done;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (srca),
    .b       (srcb),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_mul_start) w_state_next = MUL;
      MUL:     if (w_mul_done)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Shifts carry an extra bit so the last bit shifted out falls into it,
  // which also yields C=0 naturally for a zero shift amount.
  assign w_shamt = srcb[SHAMT_W-1:0];
  assign w_sum   = {1'b0, srca} + {1'b0, srcb};
  assign w_diff  = {1'b0, srca} - {1'b0, srcb};
  assign w_lsl   = {1'b0, srca} << w_shamt;
  assign w_lsr   = {srca, 1'b0} >> w_shamt;
  assign w_asr   = $signed({srca, 1'b0}) >>> w_shamt;

  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_v   = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_sc_res = w_sum[WIDTH-1:0];
        w_sc_c   = w_sum[WIDTH];
        w_sc_v   = (srca[WIDTH-1] == srcb[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_diff[WIDTH-1:0];
        w_sc_c   = ~w_diff[WIDTH];
        w_sc_v   = (srca[WIDTH-1] != srcb[WIDTH-1]) &&
                   (w_diff[WIDTH-1] != srca[WIDTH-1]);
      end
      OP_AND:  w_sc_res = srca & srcb;
      OP_OR:   w_sc_res = srca | srcb;
      OP_XOR:  w_sc_res = srca ^ srcb;
      OP_MOV:  w_sc_res = srcb;
      OP_LSL: begin
        w_sc_res = w_lsl[WIDTH-1:0];
        w_sc_c   = w_lsl[WIDTH];
      end
      OP_LSR: begin
        w_sc_res = w_lsr[WIDTH:1];
        w_sc_c   = w_lsr[0];
      end
      OP_ASR: begin
        w_sc_res = w_asr[WIDTH:1];
        w_sc_c   = w_asr[0];
      end
      OP_SLTU: w_sc_res = WIDTH'(srca < srcb);
      OP_SLT:  w_sc_res = WIDTH'($signed(srca) < $signed(srcb));
      default: w_sc_res = '0;
    endcase
  end

  always_comb begin
    w_sc_flags    = '0;
    w_sc_flags[N] = w_sc_res[WIDTH-1];
    w_sc_flags[Z] = (w_sc_res == '0);
    w_sc_flags[C] = w_sc_c;
    w_sc_flags[V] = w_sc_v;
  end

  assign w_mul_res = w_product[WIDTH-1:0];

  always_comb begin
    w_mul_flags    = '0;
    w_mul_flags[N] = w_mul_res[WIDTH-1];
    w_mul_flags[Z] = (w_mul_res == '0);
    w_mul_flags[C] = |w_product[2*WIDTH-1:WIDTH];
    w_mul_flags[V] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_single_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_sc_res;
      r_flags     <= w_sc_flags;
    end else if (w_mul_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      r_flags     <= w_mul_flags;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign negative  = r_flags[N];
  assign zero      = r_flags[Z];
  assign carryout  = r_flags[C];
  assign overflow  = r_flags[V];
  assign busy      = (r_state == MUL);

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_alu : directed stimulus with a behavioural reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 32;
  localparam logic [3:0] K_ADD = 4'b0000, K_SUB = 4'b0001, K_AND = 4'b0010,
                         K_OR  = 4'b0011, K_XOR = 4'b0100, K_LSL = 4'b0101,
                         K_LSR = 4'b0110, K_MOV = 4'b0111, K_MUL = 4'b1000,
                         K_ASR = 4'b1001, K_SLTU = 4'b1010, K_SLT = 4'b1011;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  srca = '0;
  logic [W-1:0]  srcb = '0;
  logic [3:0]    alu_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          zero, negative, carryout, overflow, busy;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .srca(srca), .srcb(srcb), .alu_op(alu_op), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero),
    .negative(negative), .carryout(carryout), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {N,Z,C,V,result} straight from the arithmetic definition of each op.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic signed [31:0] as32;
    logic c, v;
    int sh;
    longint sa, sb, ss;
    logic [63:0] p;
    logic [32:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    sh = int'(b[4:0]);
    as32 = a;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      K_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        ss = sa + sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      K_SUB: begin
        r = a - b; c = (a >= b);
        ss = sa - sb; v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      K_AND: r = a & b;
      K_OR:  r = a | b;
      K_XOR: r = a ^ b;
      K_MOV: r = b;
      K_LSL: begin r = a << sh; c = (sh == 0) ? 1'b0 : a[32-sh]; end
      K_LSR: begin r = a >> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
      K_ASR: begin r = as32 >>> sh; c = (sh == 0) ? 1'b0 : a[sh-1]; end
      K_MUL: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; c = |p[63:32]; end
      K_SLTU: r = {31'b0, a < b};
      K_SLT:  r = {31'b0, sa < sb};
      default: r = '0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  // Transaction-level expectation of what the output port should show.
  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_flags = '0;
  int          m_mul_left = 0;
  logic [35:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin : model_upd
    logic acc;
    if (!rst_n) begin
      m_valid = 1'b0; m_res = '0; m_flags = '0; m_mul_left = 0;
    end else begin
      acc = in_valid && (m_mul_left == 0) && (!m_valid || out_ready);
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_valid = 1'b1;
          {m_flags, m_res} = m_pend;
        end
      end else if (acc && alu_op != K_MUL) begin
        m_valid = 1'b1;
        {m_flags, m_res} = model(alu_op, srca, srcb);
      end else begin
        if (acc) begin
          m_mul_left = W;
          m_pend = model(alu_op, srca, srcb);
        end
        if (out_ready) m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (m_mul_left == 0) && (!m_valid || out_ready));
      chk("busy", busy, m_mul_left > 0);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("result", result, m_res);
        chk("flags", {negative, zero, carryout, overflow}, m_flags);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; alu_op = op; srca = a; srcb = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic op_chk(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef);
    do_op(op, a, b);
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_res"}, result, er);
    chk({name, "_nzcv"}, {negative, zero, carryout, overflow}, ef);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    int seen;

    // Hand-computed values pin the reference model itself.
    chk("model_add", model(K_ADD, 32'hFFFFFFFF, 32'h1), {4'b0110, 32'h0});
    chk("model_sub", model(K_SUB, 32'h80000000, 32'h1), {4'b0011, 32'h7FFFFFFF});
    chk("model_mul", model(K_MUL, 32'h10000, 32'h10000), {4'b0110, 32'h0});
    chk("model_asr", model(K_ASR, 32'h80000000, 32'h24), {4'b1000, 32'hF8000000});

    step(); step();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res", result, 32'h0);
    chk("rst_nzcv", {negative, zero, carryout, overflow}, 4'b0000);
    rst_n = 1'b1;
    step();

    op_chk("add_wrap", K_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110);
    op_chk("sub_ovf", K_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011);
    op_chk("sub_borrow", K_SUB, 32'h1, 32'h2, 32'hFFFFFFFF, 4'b1000);

    do_op(K_MUL, 32'h00010000, 32'h00010000);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("mul_latency", n, 32);
    chk("mul_hi_res", result, 32'h0);
    chk("mul_hi_nzcv", {negative, zero, carryout, overflow}, 4'b0110);
    do_op(K_MUL, 32'd7, 32'd6);
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    chk("mul2_latency", n, 32);
    chk("mul2_res", result, 32'd42);
    chk("mul2_nzcv", {negative, zero, carryout, overflow}, 4'b0000);

    op_chk("asr", K_ASR, 32'h80000000, 32'h24, 32'hF8000000, 4'b1000);
    op_chk("lsl", K_LSL, 32'h80000001, 32'h1, 32'h2, 4'b0010);
    op_chk("lsr0", K_LSR, 32'h80000001, 32'h20, 32'h80000001, 4'b1000);
    op_chk("slt", K_SLT, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0000);
    op_chk("sltu", K_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0100);
    op_chk("xor", K_XOR, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 4'b0000);
    op_chk("mov", K_MOV, 32'h1, 32'h80000000, 32'h80000000, 4'b1000);
    op_chk("illegal", 4'hD, 32'h5, 32'h6, 32'h0, 4'b0100);

    // Backpressure: hold a result while an XOR waits, then swap to OR on release.
    op_chk("bp_add", K_ADD, 32'd10, 32'd20, 32'd30, 4'b0000);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = K_XOR; srca = 32'h1; srcb = 32'h1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_res", result, 32'd30);
      chk("bp_hold_ready", in_ready, 1'b0);
    end
    alu_op = K_OR; srca = 32'hF0; srcb = 32'h0F; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_or_valid", out_valid, 1'b1);
    chk("bp_or_res", result, 32'hFF);
    step();
    chk("bp_drain", out_valid, 1'b0);

    // Reset in the middle of a multiply.
    do_op(K_MUL, 32'h12345678, 32'h3);
    for (int i = 0; i < 9; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", in_ready, 1'b1);
    chk("arst_res", result, 32'h0);
    step(); step();
    rst_n = 1'b1;
    op_chk("post_add", K_ADD, 32'd2, 32'd3, 32'd5, 4'b0000);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("no_stale_mul", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
